census_ctrl: RTL and testbench
==============================

Name: census_ctrl

Overview:
- Sequencer for one census-transform unit. The unit is a separate instance; this block drives its center/padding strobes and receives its 24-bit code.
- For each requested center pixel (row, col), it fetches the 3x3 window from a single-port image SRAM with 1-cycle read latency.
- It presents the center pixel first, then the 8 neighbours in raster order, with out-of-image neighbours flagged as padding.
- It captures the resulting 24-bit RGB census code and pulses a valid strobe.

Parameters:
- IMG_W, 16, image width in pixels.
- IMG_H, 16, image height in pixels.
- COL_W, 4, column coordinate width (ceil log2 IMG_W).
- ROW_W, 4, row coordinate width (ceil log2 IMG_H).
- ADDR_W, 8, SRAM address width (ceil log2 IMG_W*IMG_H).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request strobe, sampled only in IDLE.
- i_row  in  ROW_W  center row, sampled with i_start.
- i_col  in  COL_W  center column, sampled with i_start.
- o_busy  out  1  high from the cycle after an accepted start until o_valid, inclusive.
- o_err  out  1  1-cycle pulse: start rejected because coordinates are out of range.
- o_mem_addr  out  ADDR_W  SRAM read address = row*IMG_W + col.
- o_mem_ren  out  1  SRAM read enable.
- o_census_center  out  1  to the census unit: the current SRAM data is the center pixel.
- o_census_padding  out  1  to the census unit: the current neighbour is outside the image, treat as 0.
- i_census_data  in  24  census unit output code {R,G,B}.
- o_data  out  24  captured census code, held until the next capture.
- o_valid  out  1  1-cycle pulse: o_data is updated.

Behaviour:
- Reset: async, active-low. State returns to IDLE immediately, including mid-operation; the request in flight is discarded. All outputs are 0, o_data included.
- States and transitions:
  - IDLE. On i_start: if i_row<IMG_H and i_col<IMG_W, latch the coordinates and go to FETCH. Otherwise pulse o_err for 1 cycle and stay in IDLE.
  - FETCH. 9 issue cycles, idx 0..8. idx 0 = center (0,0). idx 1..8 = offsets (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1) as (drow,dcol).
  - DRAIN. 2 cycles: the last SRAM data reaches the census unit, then the code settles.
  - DONE. 1 cycle: o_data <= i_census_data, o_valid=1. Go to IDLE.
- Issue rules in FETCH:
  - In-range neighbour: o_mem_ren=1, address as computed.
  - Out-of-range neighbour (row or col <0 or >=dim): o_mem_ren=0, o_mem_addr holds the center address, padding flag for that slot = 1.
- Strobe alignment: o_census_center and o_census_padding are the issue-cycle flags delayed by exactly 1 register, aligned with SRAM data. Center is high only in the cycle the center data arrives. Both strobes are 0 outside these 9 data cycles.
- Neighbour bit order: the census unit shifts left, so neighbour idx 1 ends in bit 7 of each channel and idx 8 in bit 0.
- Latency: with i_start sampled high at edge E, FETCH idx 0 runs in cycle E+1 and o_valid is high in cycle E+12 (12 cycles after start). o_busy is high for cycles E+1..E+12.
- i_start while not IDLE: ignored, no error. i_start in the DONE cycle: ignored; the new request is accepted from IDLE the next cycle.
- Coordinate arithmetic: use signed (ROW_W+1)/(COL_W+1) bit intermediates for the -1 offsets. Compute the address in ADDR_W bits, no wrap.

Optional Feature:
- CENSUS_CTRL_REPLICATE_EN defined: edge-replicate padding.
  - Out-of-range neighbour coordinates are clamped to [0, IMG_H-1] / [0, IMG_W-1].
  - o_mem_ren=1 and the padding strobe stays 0 for all 8 neighbours.
- Undefined: zero padding as specified in Behaviour.
- Latency is identical in both modes.

Test Plan:
- SRAM model mem[a]={a,a,a}, IMG 16x16. Start (5,5) -> addresses 85,68,69,70,84,86,100,101,102 in order; center strobe one cycle after addr 85; o_data=0x0F0F0F, o_valid in cycle E+12.
- Start (0,0), zero padding -> padding strobes on idx 1,2,3,4,6; o_mem_ren low on those slots; o_data=0x0B0B0B.
- Start (0,0) with CENSUS_CTRL_REPLICATE_EN -> no padding strobes; clamped addresses 0,0,1,0,1,16,16,17; o_data=0x2F2F2F.
- Start (16,3) -> o_err pulse 1 cycle; o_busy stays 0; no SRAM reads.
- i_start held high continuously from (5,5) -> starts ignored while busy; next request accepted the cycle after DONE; o_valid pulses exactly 13 cycles apart.
- Assert i_rst_n low at FETCH idx 4, release, then start (15,15) -> all outputs 0 during reset; only the new code is produced: o_data=0x000000 (all in-range neighbours <=255, padded ones 0).

Source files
------------

// File: rtl/census_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : census_ctrl_if
// Brief    : Request, SRAM-read, census-unit and result signals of
//            census_ctrl, grouped into one bundle. Port names are written
//            from the controller's point of view.
// Revision : 1.0  initial release
// ============================================================================
interface census_ctrl_if #(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int ADDR_W = 8
);
  logic              i_start;
  logic [ROW_W-1:0]  i_row;
  logic [COL_W-1:0]  i_col;
  logic              o_busy;
  logic              o_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_ren;
  logic              o_census_center;
  logic              o_census_padding;
  logic [23:0]       i_census_data;
  logic [23:0]       o_data;
  logic              o_valid;

  // Controller side
  modport slave (
    input  i_start, i_row, i_col, i_census_data,
    output o_busy, o_err, o_mem_addr, o_mem_ren,
           o_census_center, o_census_padding, o_data, o_valid
  );

  // Requester / environment side
  modport master (
    output i_start, i_row, i_col, i_census_data,
    input  o_busy, o_err, o_mem_addr, o_mem_ren,
           o_census_center, o_census_padding, o_data, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/census_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : census_ctrl
// Brief    : Sequencer for one census-transform unit. For a requested center
//            pixel it reads the 3x3 window from a 1-cycle-latency SRAM
//            (center first, then the 8 neighbours in raster order), drives
//            the unit's center/padding strobes aligned with the SRAM data,
//            and captures the resulting 24-bit {R,G,B} census code.
// Options  : CENSUS_CTRL_REPLICATE_EN - when defined, out-of-image
//            neighbours are clamped to the image edge and read from SRAM
//            instead of being flagged as zero padding.
// Revision : 1.0  initial release
// ============================================================================
module census_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int COL_W  = 4,
  parameter int ROW_W  = 4,
  parameter int ADDR_W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  census_ctrl_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [3:0] c_LAST_IDX   = 4'd8;  // 9 issue slots: 0..8
  localparam logic [3:0] c_DRAIN_LAST = 4'd1;  // 2 drain cycles: 0..1

  localparam logic [ROW_W:0] c_IMG_H = (ROW_W+1)'(IMG_H);
  localparam logic [COL_W:0] c_IMG_W = (COL_W+1)'(IMG_W);

  localparam logic signed [ROW_W:0] c_ROW_M1 = '1;
  localparam logic signed [ROW_W:0] c_ROW_P1 = {{ROW_W{1'b0}}, 1'b1};
  localparam logic signed [COL_W:0] c_COL_M1 = '1;
  localparam logic signed [COL_W:0] c_COL_P1 = {{COL_W{1'b0}}, 1'b1};

`ifdef CENSUS_CTRL_REPLICATE_EN
  localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(IMG_W - 1);
`endif

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [1:0]              r_state;
  logic [1:0]              w_next_state;
  logic [3:0]              r_idx;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic                    r_err;
  logic                    r_center;
  logic                    r_pad;
  logic [23:0]             r_data;

  logic                    w_coord_ok;
  logic                    w_accept;
  logic                    w_fetch_last;
  logic                    w_drain_last;

  logic signed [ROW_W:0]   w_drow;
  logic signed [COL_W:0]   w_dcol;
  logic signed [ROW_W:0]   w_nrow;
  logic signed [COL_W:0]   w_ncol;
  logic                    w_row_oob;
  logic                    w_col_oob;
  logic                    w_pad;
  logic [ROW_W-1:0]        w_rd_row;
  logic [COL_W-1:0]        w_rd_col;
  logic [ADDR_W-1:0]       w_addr;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  assign w_coord_ok   = ({1'b0, bus.i_row} < c_IMG_H) && ({1'b0, bus.i_col} < c_IMG_W);
  assign w_accept     = (r_state == c_IDLE) && bus.i_start && w_coord_ok;
  assign w_fetch_last = (r_idx == c_LAST_IDX);
  assign w_drain_last = (r_idx == c_DRAIN_LAST);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register; reset aborts any request in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; starts outside IDLE (DONE included) are ignored.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept)     w_next_state = c_FETCH;
      c_FETCH: if (w_fetch_last) w_next_state = c_DRAIN;
      c_DRAIN: if (w_drain_last) w_next_state = c_DONE;
      c_DONE:                    w_next_state = c_IDLE;
      default:                   w_next_state = c_IDLE;
    endcase
  end

  // Output logic: status and SRAM issue, all decoded from the current state.
  always_comb begin
    bus.o_busy     = (r_state != c_IDLE);
    bus.o_valid    = (r_state == c_DONE);
    bus.o_mem_ren  = 1'b0;
    bus.o_mem_addr = '0;
    if (r_state == c_FETCH) begin
      bus.o_mem_ren  = !w_pad;
      bus.o_mem_addr = w_addr;
    end
  end

  // Slot counter shared by FETCH (issue index) and DRAIN (wait count).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if ((r_state == c_FETCH && !w_fetch_last) ||
                 (r_state == c_DRAIN && !w_drain_last)) begin
      r_idx <= r_idx + 4'd1;
    end else begin
      r_idx <= '0;
    end
  end

  // Latch the center coordinates of an accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_row <= bus.i_row;
      r_col <= bus.i_col;
    end
  end

  // --------------------------------------------------------------------------
  // Window addressing
  // --------------------------------------------------------------------------
  // Map issue slot to (drow,dcol): slot 0 is the center, 1..8 raster order.
  always_comb begin
    w_drow = '0;
    w_dcol = '0;
    case (r_idx)
      4'd1:    begin w_drow = c_ROW_M1; w_dcol = c_COL_M1; end
      4'd2:    begin w_drow = c_ROW_M1; w_dcol = '0;       end
      4'd3:    begin w_drow = c_ROW_M1; w_dcol = c_COL_P1; end
      4'd4:    begin w_drow = '0;       w_dcol = c_COL_M1; end
      4'd5:    begin w_drow = '0;       w_dcol = c_COL_P1; end
      4'd6:    begin w_drow = c_ROW_P1; w_dcol = c_COL_M1; end
      4'd7:    begin w_drow = c_ROW_P1; w_dcol = '0;       end
      4'd8:    begin w_drow = c_ROW_P1; w_dcol = c_COL_P1; end
      default: begin w_drow = '0;       w_dcol = '0;       end
    endcase
  end

  // One extra sign bit: a -1 step from 0 goes negative, and when the image
  // fills the whole coordinate range a +1 step from the last row/col also
  // lands in the negative half. Viewed unsigned, every such value is
  // >= the image dimension, so one compare flags both edges.
  assign w_nrow    = $signed({1'b0, r_row}) + w_drow;
  assign w_ncol    = $signed({1'b0, r_col}) + w_dcol;
  assign w_row_oob = ($unsigned(w_nrow) >= c_IMG_H);
  assign w_col_oob = ($unsigned(w_ncol) >= c_IMG_W);

  // Resolve the coordinate actually read and whether the slot is padding.
`ifdef CENSUS_CTRL_REPLICATE_EN
  // Clamp direction comes from the offset sign, not the wrapped sum.
  always_comb begin
    w_pad    = 1'b0;
    w_rd_row = w_nrow[ROW_W-1:0];
    w_rd_col = w_ncol[COL_W-1:0];
    if (w_row_oob) w_rd_row = w_drow[ROW_W] ? '0 : c_ROW_MAX;
    if (w_col_oob) w_rd_col = w_dcol[COL_W] ? '0 : c_COL_MAX;
  end
`else
  // Padded slots keep the center address on the bus with the read disabled.
  always_comb begin
    w_pad    = 1'b0;
    w_rd_row = r_row;
    w_rd_col = r_col;
    if (w_row_oob || w_col_oob) begin
      w_pad = 1'b1;
    end else begin
      w_rd_row = w_nrow[ROW_W-1:0];
      w_rd_col = w_ncol[COL_W-1:0];
    end
  end
`endif

  assign w_addr = (ADDR_W'(w_rd_row) * ADDR_W'(IMG_W)) + ADDR_W'(w_rd_col);

  // --------------------------------------------------------------------------
  // Strobes and result capture
  // --------------------------------------------------------------------------
  // Issue-cycle flags delayed one cycle to line up with the SRAM read data;
  // the range-error pulse is registered on the same footing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_center <= 1'b0;
      r_pad    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_center <= (r_state == c_FETCH) && (r_idx == 4'd0);
      r_pad    <= (r_state == c_FETCH) && w_pad;
      r_err    <= (r_state == c_IDLE) && bus.i_start && !w_coord_ok;
    end
  end

  // Capture the settled code on entry to DONE so o_data is new while o_valid is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (r_state == c_DRAIN && w_drain_last) begin
      r_data <= bus.i_census_data;
    end
  end

  assign bus.o_census_center  = r_center;
  assign bus.o_census_padding = r_pad;
  assign bus.o_err            = r_err;
  assign bus.o_data           = r_data;

endmodule
`default_nettype wire

// File: tb/tb_census_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_census_ctrl
// Brief    : Self-checking bench for census_ctrl with an SRAM holding
//            {a,a,a} at address a and a behavioural census unit (bit = 1
//            when neighbour > center, padding reads as 0). Expected values
//            come from a window model computed from coordinates.
// Revision : 1.0  initial release
// ============================================================================
module tb_census_ctrl;

  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int COL_W  = 5;   // one spare bit so out-of-range starts can be driven
  localparam int ROW_W  = 5;
  localparam int ADDR_W = 8;

  localparam int DR [0:8] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
  localparam int DC [0:8] = '{0, -1,  0,  1, -1, 1, -1, 0, 1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [23:0] exp_data = '0;

  always #5 clk = ~clk;

  census_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus ();

  census_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // ---------------- environment: SRAM and census unit ----------------
  logic [23:0] sram_q = '0;
  logic [23:0] cu_center;
  logic [23:0] cu_code;
  int          cu_cnt;

  always @(posedge clk)
    if (bus.o_mem_ren) sram_q <= {3{bus.o_mem_addr}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu_center <= '0;
      cu_code   <= '0;
      cu_cnt    <= 0;
    end else if (bus.o_census_center) begin
      cu_center <= sram_q;
      cu_code   <= '0;
      cu_cnt    <= 8;
    end else if (cu_cnt > 0) begin
      for (int ch = 0; ch < 3; ch++)
        cu_code[ch*8 +: 8] <= {cu_code[ch*8 +: 7],
                               (!bus.o_census_padding && (sram_q[ch*8 +: 8] > cu_center[ch*8 +: 8]))};
      cu_cnt <= cu_cnt - 1;
    end
  end

  assign bus.i_census_data = cu_code;

  // ---------------- reference model ----------------
  function automatic void model_slot(input int row, input int col, input int k,
                                     output int addr, output bit ren, output bit pad);
    int r;
    int c;
    r = row + DR[k];
    c = col + DC[k];
`ifdef CENSUS_CTRL_REPLICATE_EN
    if (r < 0) r = 0;
    if (r > IMG_H - 1) r = IMG_H - 1;
    if (c < 0) c = 0;
    if (c > IMG_W - 1) c = IMG_W - 1;
    addr = r * IMG_W + c;
    ren  = 1'b1;
    pad  = 1'b0;
`else
    if (r >= 0 && r < IMG_H && c >= 0 && c < IMG_W) begin
      addr = r * IMG_W + c;
      ren  = 1'b1;
      pad  = 1'b0;
    end else begin
      addr = row * IMG_W + col;
      ren  = 1'b0;
      pad  = 1'b1;
    end
`endif
  endfunction

  function automatic logic [23:0] model_code(input int row, input int col);
    int a;
    int cen;
    bit ren;
    bit pad;
    logic [7:0] b;
    b = '0;
    model_slot(row, col, 0, cen, ren, pad);
    for (int k = 1; k < 9; k++) begin
      model_slot(row, col, k, a, ren, pad);
      if (!pad && a > cen) b[8-k] = 1'b1;
    end
    return {b, b, b};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_busy, bus.o_valid, bus.o_err, bus.o_mem_ren, bus.o_census_center,
         bus.o_census_padding, bus.o_mem_addr, bus.o_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b err=%b ren=%b cen=%b pad=%b addr=%0d data=%h, expected all 0",
               bus.o_busy, bus.o_valid, bus.o_err, bus.o_mem_ren, bus.o_census_center,
               bus.o_census_padding, bus.o_mem_addr, bus.o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.o_busy);
    end
  endtask

  // One complete request with cycle-by-cycle checks; poke drives stray starts while busy and in DONE.
  task automatic test_window(input int row, input int col, input bit poke);
    int ea [9];
    bit er [9];
    bit ep [9];
    logic [23:0] ecode;
    logic [23:0] edat;
    bit e_cen;
    bit e_pad;
    for (int k = 0; k < 9; k++) model_slot(row, col, k, ea[k], er[k], ep[k]);
    ecode = model_code(row, col);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_row   = ROW_W'(row);
    bus.i_col   = COL_W'(col);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (bus.o_busy !== 1'(n <= 12)) begin
        errors++;
        $display("FAIL busy (%0d,%0d) cyc=%0d: got %b expected %b", row, col, n, bus.o_busy, n <= 12);
      end
      checks++;
      if (bus.o_valid !== 1'(n == 12)) begin
        errors++;
        $display("FAIL valid (%0d,%0d) cyc=%0d: got %b expected %b", row, col, n, bus.o_valid, n == 12);
      end
      checks++;
      if (bus.o_err !== 1'b0) begin
        errors++;
        $display("FAIL err_busy (%0d,%0d) cyc=%0d: got %b expected 0", row, col, n, bus.o_err);
      end
      e_cen = (n == 2);
      e_pad = (n >= 3 && n <= 10) ? ep[n-2] : 1'b0;
      checks++;
      if (bus.o_census_center !== e_cen) begin
        errors++;
        $display("FAIL center_strobe (%0d,%0d) cyc=%0d: got %b expected %b", row, col, n, bus.o_census_center, e_cen);
      end
      checks++;
      if (bus.o_census_padding !== e_pad) begin
        errors++;
        $display("FAIL pad_strobe (%0d,%0d) cyc=%0d: got %b expected %b", row, col, n, bus.o_census_padding, e_pad);
      end
      if (n <= 9) begin
        checks++;
        if (bus.o_mem_ren !== er[n-1]) begin
          errors++;
          $display("FAIL mem_ren (%0d,%0d) idx=%0d: got %b expected %b", row, col, n-1, bus.o_mem_ren, er[n-1]);
        end
        checks++;
        if (bus.o_mem_addr !== ADDR_W'(ea[n-1])) begin
          errors++;
          $display("FAIL mem_addr (%0d,%0d) idx=%0d: got %0d expected %0d", row, col, n-1, bus.o_mem_addr, ea[n-1]);
        end
      end else begin
        checks++;
        if (bus.o_mem_ren !== 1'b0) begin
          errors++;
          $display("FAIL mem_ren_idle (%0d,%0d) cyc=%0d: got %b expected 0", row, col, n, bus.o_mem_ren);
        end
      end
      edat = (n >= 12) ? ecode : exp_data;
      checks++;
      if (bus.o_data !== edat) begin
        errors++;
        $display("FAIL data (%0d,%0d) cyc=%0d: got %h expected %h", row, col, n, bus.o_data, edat);
      end
      if (poke) begin
        if (n == 4) begin
          bus.i_start = 1'b1;
          bus.i_row   = ROW_W'($urandom_range(0, 31));
          bus.i_col   = COL_W'($urandom_range(0, 31));
        end
        if (n == 12) begin
          bus.i_start = 1'b1;
          bus.i_row   = ROW_W'($urandom_range(0, 15));
          bus.i_col   = COL_W'($urandom_range(0, 15));
        end
        if (n == 5 || n == 13) bus.i_start = 1'b0;
      end
    end
    exp_data = ecode;
  endtask

  task automatic test_error();
    int r;
    int c;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        r = 16; c = 3;
      end else if (i[0]) begin
        r = $urandom_range(16, 31); c = $urandom_range(0, 31);
      end else begin
        r = $urandom_range(0, 15);  c = $urandom_range(16, 31);
      end
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_row   = ROW_W'(r);
      bus.i_col   = COL_W'(c);
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      for (int n = 1; n <= 3; n++) begin
        if (n > 1) begin
          @(posedge clk);
          #1;
        end
        checks++;
        if (bus.o_err !== 1'(n == 1)) begin
          errors++;
          $display("FAIL err_pulse (%0d,%0d) cyc=%0d: got %b expected %b", r, c, n, bus.o_err, n == 1);
        end
        checks++;
        if ({bus.o_busy, bus.o_mem_ren, bus.o_valid} !== 3'b000) begin
          errors++;
          $display("FAIL err_quiet (%0d,%0d) cyc=%0d: got busy/ren/valid=%b expected 000", r, c, n,
                   {bus.o_busy, bus.o_mem_ren, bus.o_valid});
        end
      end
      checks++;
      if (bus.o_data !== exp_data) begin
        errors++;
        $display("FAIL err_data_hold: got %h expected %h", bus.o_data, exp_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcyc [$];
    int errs_seen;
    logic [23:0] ecode;
    ecode = model_code(5, 5);
    errs_seen = 0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_row   = ROW_W'(5);
    bus.i_col   = COL_W'(5);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_err) errs_seen++;
      if (bus.o_valid) begin
        vcyc.push_back(n);
        checks++;
        if (bus.o_data !== ecode) begin
          errors++;
          $display("FAIL b2b_data cyc=%0d: got %h expected %h", n, bus.o_data, ecode);
        end
      end
      if (n == 13 || n == 26 || n == 39) begin
        checks++;
        if (bus.o_busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap cyc=%0d: got busy=%b expected 0", n, bus.o_busy);
        end
      end
      if (n == 14 || n == 27) begin
        checks++;
        if (bus.o_busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_reaccept cyc=%0d: got busy=%b expected 1", n, bus.o_busy);
        end
      end
      if (n == 27) bus.i_start = 1'b0;
    end
    checks++;
    if (vcyc.size() !== 3) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d expected 3", vcyc.size());
    end else begin
      checks++;
      if (vcyc[0] !== 12) begin
        errors++;
        $display("FAIL b2b_first_latency: got %0d expected 12", vcyc[0]);
      end
      checks++;
      if (vcyc[1] - vcyc[0] !== 13) begin
        errors++;
        $display("FAIL b2b_spacing1: got %0d expected 13", vcyc[1] - vcyc[0]);
      end
      checks++;
      if (vcyc[2] - vcyc[1] !== 13) begin
        errors++;
        $display("FAIL b2b_spacing2: got %0d expected 13", vcyc[2] - vcyc[1]);
      end
    end
    checks++;
    if (errs_seen !== 0) begin
      errors++;
      $display("FAIL b2b_err: got %0d err pulses expected 0", errs_seen);
    end
    exp_data = ecode;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      test_window($urandom_range(0, IMG_H - 1), $urandom_range(0, IMG_W - 1), i[0]);
    end
  endtask

  task automatic test_reset_midop();
    int ea;
    bit er;
    bit ep;
    int vseen;
    model_slot(5, 5, 4, ea, er, ep);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_row   = ROW_W'(5);
    bus.i_col   = COL_W'(5);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_mem_ren, bus.o_mem_addr} !== {er, ADDR_W'(ea)}) begin
      errors++;
      $display("FAIL midop_idx4: got ren=%b addr=%0d expected ren=%b addr=%0d", bus.o_mem_ren, bus.o_mem_addr, er, ea);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_valid, bus.o_err, bus.o_mem_ren, bus.o_census_center,
         bus.o_census_padding, bus.o_mem_addr, bus.o_data} !== '0) begin
      errors++;
      $display("FAIL midop_async_reset: got busy=%b valid=%b err=%b ren=%b cen=%b pad=%b addr=%0d data=%h, expected all 0",
               bus.o_busy, bus.o_valid, bus.o_err, bus.o_mem_ren, bus.o_census_center,
               bus.o_census_padding, bus.o_mem_addr, bus.o_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.o_busy, bus.o_mem_ren, bus.o_data} !== '0) begin
      errors++;
      $display("FAIL midop_held_reset: got busy=%b ren=%b data=%h expected 0", bus.o_busy, bus.o_mem_ren, bus.o_data);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    exp_data = '0;
    vseen    = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (bus.o_valid || bus.o_busy) vseen++;
    end
    checks++;
    if (vseen !== 0) begin
      errors++;
      $display("FAIL midop_discard: got %0d busy/valid cycles after reset expected 0", vseen);
    end
    test_window(15, 15, 1'b0);
    checks++;
    if (bus.o_data !== 24'h000000) begin
      errors++;
      $display("FAIL midop_new_code: got %h expected 000000", bus.o_data);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.i_start = 1'b0;
    bus.i_row   = '0;
    bus.i_col   = '0;
    test_reset();
    test_window(5, 5, 1'b0);
    test_window(0, 0, 1'b0);
    test_window(15, 15, 1'b1);
    test_window(0, 15, 1'b0);
    test_window(15, 0, 1'b1);
    test_error();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
